branch_predictor: RTL

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 88 ++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// PC word-address bits, with a registered lookup port, an independent update
// port, and counters for resolved and mispredicted branches.
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        predict_valid,
  input  logic [31:0] predict_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic        update_predicted,
  output logic [15:0] branch_count,
  output logic [15:0] mispredict_count
);

  localparam int ENTRIES = 2 ** IDX_BITS;

  // 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  logic [1:0]          ctr_table [ENTRIES];
  logic [IDX_BITS-1:0] predict_idx;
  logic [IDX_BITS-1:0] update_idx;
  logic [1:0]          update_cur;
  logic [1:0]          update_next;

  // Low two bits are the byte offset within a word; bits above the index
  // alias onto the same entry by design.
  assign predict_idx = predict_pc[IDX_BITS+1:2];
  assign update_idx  = update_pc[IDX_BITS+1:2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{predict_pc[31:IDX_BITS+2], predict_pc[1:0],
                            update_pc[31:IDX_BITS+2], update_pc[1:0]};

  assign update_cur = ctr_table[update_idx];

  // Saturating increment on taken, saturating decrement on not-taken.
  always_comb begin
    update_next = update_cur;
    if (update_taken) begin
      if (update_cur != CTR_STRONG_T) update_next = update_cur + 2'd1;
    end else begin
      if (update_cur != CTR_STRONG_NT) update_next = update_cur - 2'd1;
    end
  end

  // Counter table: reset to weak-NT, written only on a valid update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= CTR_WEAK_NT;
    end else if (update_valid) begin
      ctr_table[update_idx] <= update_next;
    end
  end

  // Registered lookup; reads the pre-update value when indices collide, and
  // pred_taken holds between requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= predict_valid;
      if (predict_valid) pred_taken <= ctr_table[predict_idx][1];
    end
  end

  // Resolved-branch and misprediction statistics, wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count     <= 16'd0;
      mispredict_count <= 16'd0;
    end else if (update_valid) begin
      branch_count <= branch_count + 16'd1;
      if (update_taken != update_predicted)
        mispredict_count <= mispredict_count + 16'd1;
    end
  end

endmodule
